// File: rtl/cu_pkg.sv
// Shared control-unit definitions: control-word width, the bit position of
// each named decoder output, and the word type used across the slice.
package cu_pkg;

    localparam int CU_WORD_W = 11;

    // Bit positions of the decoder outputs inside the control word.
    localparam int CU_P  = 10;
    localparam int CU_Q  = 9;
    localparam int CU_R  = 8;
    localparam int CU_S  = 7;
    localparam int CU_T  = 6;
    localparam int CU_U  = 5;
    localparam int CU_V  = 4;
    localparam int CU_W  = 3;
    localparam int CU_XX = 2;
    localparam int CU_Y  = 1;
    localparam int CU_Z  = 0;

    typedef logic [CU_WORD_W-1:0] cu_word_t;

endpackage

// File: rtl/cu_word_mem.sv
// Storage array for the control-word FIFO.
// One synchronous write port, one asynchronous read port, contents not reset.
module cu_word_mem
    import cu_pkg::*;
#(
    parameter int WIDTH = CU_WORD_W,
    parameter int DEPTH = 4,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic [AW-1:0]    raddr,
    output logic [WIDTH-1:0] rdata
);

    logic [WIDTH-1:0] r_mem [DEPTH];

    // Capture the offered word into the addressed entry.
    always_ff @(posedge clk) begin
        if (we) begin
            r_mem[waddr] <= wdata;
        end
    end

    assign rdata = r_mem[raddr];

endmodule

// File: rtl/cu_word_fifo.sv
// Control-word FIFO behind the non-stalling decoder: buffers words, drops
// consecutive duplicates, and flags words lost while full.
module cu_word_fifo
    import cu_pkg::*;
#(
    parameter int WIDTH = CU_WORD_W,
    parameter int DEPTH = 4,
    parameter bit DEDUP = 1'b1,
    localparam int AW   = $clog2(DEPTH),
    localparam int LW   = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_word,
    output logic             in_ready,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_word,
    input  logic             out_ready,
    output logic [LW-1:0]    level,
    output logic             ovf,
    input  logic             clr_ovf
);

    localparam logic [LW-1:0] FULL_LVL = LW'(DEPTH);

    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [LW-1:0]    r_level;
    logic             r_ovf;
    logic             r_last_vld;
    logic [WIDTH-1:0] r_last_word;
    logic             r_written;

    logic             w_dup;
    logic             w_push;
    logic             w_pop;
    logic             w_ovf_set;
    logic [WIDTH-1:0] w_rdata;

    assign in_ready  = (r_level != FULL_LVL);
    assign out_valid = (r_level != '0);
    assign level     = r_level;
    assign ovf       = r_ovf;

    assign w_dup     = DEDUP && r_last_vld && (in_word == r_last_word);
    assign w_push    = in_valid && in_ready && !w_dup;
    assign w_pop     = out_valid && out_ready;
    assign w_ovf_set = in_valid && !in_ready && !w_dup;

    // Until the first write after reset the head reads as zero rather than
    // whatever the unreset array happens to hold.
    assign out_word  = r_written ? w_rdata : '0;

    cu_word_mem #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_mem (
        .clk   (clk),
        .we    (w_push),
        .waddr (r_wr_ptr),
        .wdata (in_word),
        .raddr (r_rd_ptr),
        .rdata (w_rdata)
    );

    // Pointer and occupancy tracking; level is kept apart from the
    // pointers so full and empty never alias.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            if (w_push && !w_pop) begin
                r_level <= r_level + LW'(1);
            end else if (w_pop && !w_push) begin
                r_level <= r_level - LW'(1);
            end
        end
    end

    // Remember the last accepted word for duplicate suppression.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_last_vld  <= 1'b0;
            r_last_word <= '0;
            r_written   <= 1'b0;
        end else if (w_push) begin
            r_last_vld  <= 1'b1;
            r_last_word <= in_word;
            r_written   <= 1'b1;
        end
    end

    // Sticky overflow; a new loss in the same cycle as a clear keeps it set.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ovf <= 1'b0;
        end else if (w_ovf_set) begin
            r_ovf <= 1'b1;
        end else if (clr_ovf) begin
            r_ovf <= 1'b0;
        end
    end

endmodule

// File: tb/tb_cu_word_fifo.sv
// Directed bench for cu_word_fifo with a word scoreboard on the output side.
// Inputs change #1 after the rising edge; outputs are sampled there too.
module tb_cu_word_fifo;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic [10:0] in_word;
    logic        in_ready;
    logic        out_valid;
    logic [10:0] out_word;
    logic        out_ready;
    logic [2:0]  level;
    logic        ovf;
    logic        clr_ovf;

    int n_cmp = 0;
    int n_err = 0;
    logic [10:0] sb [$];

    cu_word_fifo dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_word   (in_word),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_word  (out_word),
        .out_ready (out_ready),
        .level     (level),
        .ovf       (ovf),
        .clr_ovf   (clr_ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock; if the head is being consumed, score it first.
    task automatic cyc();
        logic [10:0] e;
        if (out_valid && out_ready) begin
            if (sb.size() == 0) begin
                chk("unexpected_pop", 32'(out_word), 32'h7ff_ffff);
            end else begin
                e = sb.pop_front();
                chk("pop_word", 32'(out_word), 32'(e));
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic offer(input logic [10:0] w, input bit accept);
        in_valid = 1'b1;
        in_word  = w;
        if (accept) sb.push_back(w);
        cyc();
    endtask

    task automatic drain();
        out_ready = 1'b1;
        in_valid  = 1'b0;
        for (int i = 0; i < 12 && out_valid; i++) cyc();
        chk("drain_empty", 32'(out_valid), 32'd0);
        chk("drain_sb", 32'(sb.size()), 32'd0);
    endtask

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_word   = '0;
        out_ready = 1'b1;
        clr_ovf   = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        cyc();

        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_level", 32'(level), 32'd0);
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_ovf", 32'(ovf), 32'd0);
        chk("rst_out_word", 32'(out_word), 32'd0);

        out_ready = 1'b0;
        offer(11'h401, 1'b1);
        chk("p_valid", 32'(out_valid), 32'd1);
        chk("p_word", 32'(out_word), 32'h401);
        chk("p_level", 32'(level), 32'd1);
        for (int i = 0; i < 3; i++) begin
            offer(11'h401, 1'b0);
            chk("dup_level", 32'(level), 32'd1);
        end
        offer(11'h402, 1'b1);
        chk("q_level", 32'(level), 32'd2);
        drain();

        out_ready = 1'b0;
        for (int i = 1; i <= 4; i++) offer(11'(i), 1'b1);
        chk("full_level", 32'(level), 32'd4);
        chk("full_in_ready", 32'(in_ready), 32'd0);
        offer(11'h005, 1'b0);
        chk("ovf_set", 32'(ovf), 32'd1);
        chk("ovf_level", 32'(level), 32'd4);
        clr_ovf = 1'b1;
        offer(11'h006, 1'b0);
        chk("set_wins", 32'(ovf), 32'd1);
        in_valid = 1'b0;
        cyc();
        clr_ovf = 1'b0;
        chk("ovf_clr", 32'(ovf), 32'd0);
        offer(11'h004, 1'b0);
        chk("dup_full_no_ovf", 32'(ovf), 32'd0);
        chk("dup_full_level", 32'(level), 32'd4);
        drain();

        out_ready = 1'b0;
        offer(11'h00e, 1'b1);
        offer(11'h00f, 1'b1);
        chk("pre_stream_level", 32'(level), 32'd2);
        out_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            offer(11'(16 + i), 1'b1);
            chk("stream_level", 32'(level), 32'd2);
        end
        chk("stream_ovf", 32'(ovf), 32'd0);
        drain();

        out_ready = 1'b0;
        offer(11'h020, 1'b1);
        offer(11'h021, 1'b1);
        offer(11'h022, 1'b1);
        chk("prerst_level", 32'(level), 32'd3);
        in_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_level", 32'(level), 32'd0);
        chk("mid_rst_valid", 32'(out_valid), 32'd0);
        chk("mid_rst_word", 32'(out_word), 32'd0);
        sb.delete();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        offer(11'h022, 1'b1);
        chk("post_rst_level", 32'(level), 32'd1);
        chk("post_rst_word", 32'(out_word), 32'h022);
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
